// File: rtl/rast_pkg.sv
// Shared rasterizer types and subsample decode helpers used by the sample
// iterator and its stepping logic.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    // One-hot subsample mode to log2 of samples per pixel edge; illegal codes fall back to 1x.
    function automatic logic [1:0] ss_w_lg2_f(input logic [3:0] sub_sample);
        case (sub_sample)
            4'b0001: ss_w_lg2_f = 2'd3;
            4'b0010: ss_w_lg2_f = 2'd2;
            4'b0100: ss_w_lg2_f = 2'd1;
            4'b1000: ss_w_lg2_f = 2'd0;
            default: ss_w_lg2_f = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] step_f(input logic [1:0] ss_w_lg2, input int radix);
        step_f = 32'd1 << (radix - int'(ss_w_lg2));
    endfunction

endpackage

// File: rtl/smpl_iter_step.sv
// Raster-order stepping: computes the next sample position and the
// end-of-row / end-of-box flags for the current sample.
module smpl_iter_step #(
    parameter int SIGFIG = 24
) (
    input  logic [2*SIGFIG-1:0] sample,
    input  logic [SIGFIG-1:0]   ll_x,
    input  logic [2*SIGFIG-1:0] ur,
    input  logic [SIGFIG-1:0]   step,
    output logic [2*SIGFIG-1:0] next_sample,
    output logic                at_end_x,
    output logic                last
);

    logic signed [SIGFIG:0] sum_x_s;
    logic signed [SIGFIG:0] sum_y_s;
    logic signed [SIGFIG:0] ur_x_s;
    logic signed [SIGFIG:0] ur_y_s;
    logic                   at_end_y_s;

    // One extra bit keeps sample+step from wrapping near the top of the range.
    assign sum_x_s = $signed({sample[SIGFIG-1], sample[SIGFIG-1:0]}) + $signed({1'b0, step});
    assign sum_y_s = $signed({sample[2*SIGFIG-1], sample[2*SIGFIG-1:SIGFIG]}) + $signed({1'b0, step});
    assign ur_x_s  = $signed({ur[SIGFIG-1], ur[SIGFIG-1:0]});
    assign ur_y_s  = $signed({ur[2*SIGFIG-1], ur[2*SIGFIG-1:SIGFIG]});

    assign at_end_x   = (sum_x_s > ur_x_s);
    assign at_end_y_s = (sum_y_s > ur_y_s);
    assign last       = at_end_x && at_end_y_s;

    // Advance along the row, or wrap to LL.x on the next row.
    always_comb begin
        next_sample = sample;
        if (!at_end_x) begin
            next_sample = {sample[2*SIGFIG-1:SIGFIG], sum_x_s[SIGFIG-1:0]};
        end else begin
            next_sample = {sum_y_s[SIGFIG-1:0], ll_x};
        end
    end

endmodule

// File: rtl/smpl_iter.sv
// Sample iterator: accepts a triangle with its snapped bounding box and emits
// every sample position in the box in raster order, one per cycle.
module smpl_iter
    import rast_pkg::*;
#(
    parameter int SIGFIG = rast_pkg::SIGFIG,
    parameter int RADIX  = rast_pkg::RADIX,
    parameter int VERTS  = rast_pkg::VERTS,
    parameter int AXIS   = rast_pkg::AXIS,
    parameter int COLORS = rast_pkg::COLORS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIGFIG*VERTS*AXIS-1:0]     tri_R13S,
    input  logic [SIGFIG*COLORS-1:0]         color_R13U,
    input  logic [SIGFIG*4-1:0]              box_R13S,
    input  logic                             validTri_R13H,
    input  logic [3:0]                       subSample_RnnnnU,
    input  logic [SIGFIG*2-1:0]              screen_RnnnnS,
    output logic                             halt_RnnnnL,
    output logic [SIGFIG*VERTS*AXIS-1:0]     tri_R14S,
    output logic [SIGFIG*COLORS-1:0]         color_R14U,
    output logic [SIGFIG*2-1:0]              sample_R14S,
    output logic                             validSamp_R14H
);

    localparam int TRI_W = SIGFIG * VERTS * AXIS;
    localparam int COL_W = SIGFIG * COLORS;

    state_t                state_r,  state_nxt_s;
    logic [TRI_W-1:0]      tri_r,    tri_nxt_s;
    logic [COL_W-1:0]      color_r,  color_nxt_s;
    logic [2*SIGFIG-1:0]   sample_r, sample_nxt_s;
    logic                  valid_r,  valid_nxt_s;
    logic [SIGFIG-1:0]     ll_x_r,   ll_x_nxt_s;
    logic [2*SIGFIG-1:0]   ur_r,     ur_nxt_s;
    logic [SIGFIG-1:0]     step_r,   step_nxt_s;

    logic [SIGFIG-1:0]     box_ll_x_s;
    logic [SIGFIG-1:0]     box_ll_y_s;
    logic [SIGFIG-1:0]     box_ur_x_s;
    logic [SIGFIG-1:0]     box_ur_y_s;
    logic [SIGFIG-1:0]     step_s;
    logic [2*SIGFIG-1:0]   next_sample_s;
    logic                  at_end_x_s;
    logic                  last_s;
    logic                  degenerate_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  unused_s;

    assign box_ll_x_s = box_R13S[SIGFIG-1:0];
    assign box_ll_y_s = box_R13S[2*SIGFIG-1:SIGFIG];
    assign box_ur_x_s = box_R13S[3*SIGFIG-1:2*SIGFIG];
    assign box_ur_y_s = box_R13S[4*SIGFIG-1:3*SIGFIG];

    assign step_s = SIGFIG'(step_f(ss_w_lg2_f(subSample_RnnnnU), RADIX));

    assign degenerate_s = ($signed(box_ll_x_s) > $signed(box_ur_x_s)) ||
                          ($signed(box_ll_y_s) > $signed(box_ur_y_s));

    smpl_iter_step #(
        .SIGFIG (SIGFIG)
    ) u_step (
        .sample      (sample_r),
        .ll_x        (ll_x_r),
        .ur          (ur_r),
        .step        (step_r),
        .next_sample (next_sample_s),
        .at_end_x    (at_end_x_s),
        .last        (last_s)
    );

    // Upstream may only advance when idle or when the final sample of the box is out.
    assign halt_RnnnnL = (state_r == WAIT_STATE) || last_s;
    assign accept_s    = validTri_R13H && halt_RnnnnL;
    assign load_s      = accept_s && !degenerate_s;

    assign unused_s = (^screen_RnnnnS) ^ at_end_x_s;

    // Next-state and datapath selection: load, step, or retire.
    always_comb begin
        state_nxt_s  = state_r;
        tri_nxt_s    = tri_r;
        color_nxt_s  = color_r;
        sample_nxt_s = sample_r;
        valid_nxt_s  = valid_r;
        ll_x_nxt_s   = ll_x_r;
        ur_nxt_s     = ur_r;
        step_nxt_s   = step_r;
        if (load_s) begin
            state_nxt_s  = TEST_STATE;
            tri_nxt_s    = tri_R13S;
            color_nxt_s  = color_R13U;
            sample_nxt_s = {box_ll_y_s, box_ll_x_s};
            valid_nxt_s  = 1'b1;
            ll_x_nxt_s   = box_ll_x_s;
            ur_nxt_s     = {box_ur_y_s, box_ur_x_s};
            step_nxt_s   = step_s;
        end else if (state_r == TEST_STATE) begin
            if (last_s) begin
                state_nxt_s = WAIT_STATE;
                valid_nxt_s = 1'b0;
            end else begin
                sample_nxt_s = next_sample_s;
            end
        end else begin
            state_nxt_s = state_r;
            valid_nxt_s = valid_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= WAIT_STATE;
            tri_r    <= {TRI_W{1'b0}};
            color_r  <= {COL_W{1'b0}};
            sample_r <= {(2*SIGFIG){1'b0}};
            valid_r  <= 1'b0;
            ll_x_r   <= {SIGFIG{1'b0}};
            ur_r     <= {(2*SIGFIG){1'b0}};
            step_r   <= {SIGFIG{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            tri_r    <= tri_nxt_s;
            color_r  <= color_nxt_s;
            sample_r <= sample_nxt_s;
            valid_r  <= valid_nxt_s;
            ll_x_r   <= ll_x_nxt_s;
            ur_r     <= ur_nxt_s;
            step_r   <= step_nxt_s;
        end
    end

    assign tri_R14S       = tri_r;
    assign color_R14U     = color_r;
    assign sample_R14S    = sample_r;
    assign validSamp_R14H = valid_r;

endmodule

// File: tb/tb_smpl_iter.sv
// Randomized bench for smpl_iter against a queue-based model of the
// expected raster-order sample stream.
module tb_smpl_iter;

    localparam int S  = 24;
    localparam int TW = S * 9;
    localparam int CW = S * 3;

    typedef struct {
        int           llx, lly, urx, ury;
        logic [3:0]   ss;
        logic [TW-1:0] tri_v;
        logic [CW-1:0] col;
    } tri_t;

    typedef struct {
        int           x, y;
        logic         last;
        logic [TW-1:0] tri_v;
        logic [CW-1:0] col;
    } samp_t;

    logic            clk;
    logic            rst;
    logic [TW-1:0]   tri_R13S;
    logic [CW-1:0]   color_R13U;
    logic [4*S-1:0]  box_R13S;
    logic            validTri_R13H;
    logic [3:0]      subSample_RnnnnU;
    logic [2*S-1:0]  screen_RnnnnS;
    logic            halt_RnnnnL;
    logic [TW-1:0]   tri_R14S;
    logic [CW-1:0]   color_R14U;
    logic [2*S-1:0]  sample_R14S;
    logic            validSamp_R14H;

    smpl_iter dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .screen_RnnnnS    (screen_RnnnnS),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    tri_t       pend[$];
    samp_t      expq[$];
    bit         presenting = 1'b0;
    bit         rand_gaps  = 1'b0;
    logic [3:0] ss_idle    = 4'b1000;
    int         samp_count = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b0001: return 128;
            4'b0010: return 256;
            4'b0100: return 512;
            default: return 1024;
        endcase
    endfunction

    // Expected stream of one accepted triangle: full grid from LL, row by row.
    task automatic expand(input tri_t t);
        int st, nx, ny;
        samp_t s;
        if (t.llx > t.urx || t.lly > t.ury) return;
        st = step_of(t.ss);
        nx = (t.urx - t.llx) / st + 1;
        ny = (t.ury - t.lly) / st + 1;
        for (int j = 0; j < ny; j++) begin
            for (int i = 0; i < nx; i++) begin
                s.x     = t.llx + i * st;
                s.y     = t.lly + j * st;
                s.last  = (i == nx - 1) && (j == ny - 1);
                s.tri_v = t.tri_v;
                s.col   = t.col;
                expq.push_back(s);
            end
        end
    endtask

    task automatic add_tri(input int llx, input int lly, input int urx, input int ury, input logic [3:0] ss);
        tri_t t;
        t.llx = llx; t.lly = lly; t.urx = urx; t.ury = ury; t.ss = ss;
        for (int i = 0; i < TW / 8; i++) t.tri_v[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < CW / 8; i++) t.col[i*8 +: 8] = 8'($urandom);
        pend.push_back(t);
    endtask

    // One clock: check outputs against the model, then drive the next inputs.
    task automatic cycle();
        samp_t cur;
        tri_t  h;
        bit    have;
        bit    mhalt;
        @(negedge clk);
        have = (expq.size() > 0);
        if (have) begin
            cur = expq.pop_front();
            samp_count++;
            check_eq("valid", validSamp_R14H, 1'b1);
            check_eq("sample_x", sample_R14S[S-1:0], cur.x[S-1:0]);
            check_eq("sample_y", sample_R14S[2*S-1:S], cur.y[S-1:0]);
            check_eq("tri", tri_R14S, cur.tri_v);
            check_eq("color", color_R14U, cur.col);
        end else begin
            check_eq("idle_valid", validSamp_R14H, 1'b0);
        end
        mhalt = !have || cur.last;
        check_eq("halt", halt_RnnnnL, mhalt);

        if (rand_gaps) ss_idle = 4'(4'b0001 << $urandom_range(0, 3));
        if (!presenting && pend.size() > 0 && (!rand_gaps || $urandom_range(0, 1) == 1))
            presenting = 1'b1;
        if (presenting) begin
            h = pend[0];
            tri_R13S         = h.tri_v;
            color_R13U       = h.col;
            box_R13S         = {h.ury[S-1:0], h.urx[S-1:0], h.lly[S-1:0], h.llx[S-1:0]};
            subSample_RnnnnU = h.ss;
            validTri_R13H    = 1'b1;
            if (mhalt) begin
                expand(h);
                void'(pend.pop_front());
                presenting = 1'b0;
            end
        end else begin
            validTri_R13H    = 1'b0;
            subSample_RnnnnU = ss_idle;
        end
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        while ((pend.size() > 0 || expq.size() > 0 || presenting) && n < bound) begin
            cycle();
            n++;
        end
        check_eq("drain", (pend.size() == 0 && expq.size() == 0), 1'b1);
        cycle();
        cycle();
    endtask

    initial begin
        int st, llx, lly, urx, ury;
        logic [3:0] ss;
        rst              = 1'b1;
        tri_R13S         = '0;
        color_R13U       = '0;
        box_R13S         = '0;
        validTri_R13H    = 1'b0;
        subSample_RnnnnU = 4'b1000;
        screen_RnnnnS    = {24'd1080 << 10, 24'd1920 << 10};

        repeat (2) @(negedge clk);
        check_eq("rst_valid", validSamp_R14H, 1'b0);
        check_eq("rst_sample", sample_R14S, 48'd0);
        check_eq("rst_tri", tri_R14S, 216'd0);
        check_eq("rst_color", color_R14U, 72'd0);
        check_eq("rst_halt", halt_RnnnnL, 1'b1);
        rst = 1'b0;

        add_tri(0, 0, 1024, 512, 4'b0100);
        run_idle(50);
        add_tri(2048, 1024, 2048, 1024, 4'b1000);
        run_idle(50);
        add_tri(0, 0, 512, 0, 4'b0100);
        add_tri(1024, 1024, 1024, 1536, 4'b0100);
        run_idle(50);
        add_tri(1024, 0, 0, 512, 4'b0100);
        run_idle(50);
        ss_idle = 4'b1000;
        add_tri(0, 0, 256, 256, 4'b0001);
        run_idle(50);
        add_tri(8386560, 0, 8388607, 0, 4'b1000);
        run_idle(50);
        add_tri(-2048, -1024, 0, 0, 4'b1000);
        run_idle(50);

        // Reset in the middle of a six-sample burst.
        ss_idle = 4'b0100;
        add_tri(0, 0, 1024, 512, 4'b0100);
        samp_count = 0;
        for (int n = 0; n < 20 && samp_count < 3; n++) cycle();
        check_eq("reach_third", samp_count, 3);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", validSamp_R14H, 1'b0);
        check_eq("mid_rst_sample", sample_R14S, 48'd0);
        check_eq("mid_rst_tri", tri_R14S, 216'd0);
        check_eq("mid_rst_color", color_R14U, 72'd0);
        check_eq("mid_rst_halt", halt_RnnnnL, 1'b1);
        expq.delete();
        pend.delete();
        presenting    = 1'b0;
        validTri_R13H = 1'b0;
        @(negedge clk);
        check_eq("rst_hold_valid", validSamp_R14H, 1'b0);
        rst = 1'b0;
        add_tri(-512, 256, 0, 512, 4'b0100);
        run_idle(50);

        rand_gaps = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ss  = 4'(4'b0001 << $urandom_range(0, 3));
            st  = step_of(ss);
            llx = (int'($urandom_range(0, 40)) - 20) * 128;
            lly = (int'($urandom_range(0, 40)) - 20) * 128;
            urx = llx + int'($urandom_range(0, 3)) * st + int'($urandom_range(0, 1)) * 64;
            ury = lly + int'($urandom_range(0, 3)) * st;
            if ($urandom_range(0, 7) == 0) urx = llx - 128;
            add_tri(llx, lly, urx, ury, ss);
        end
        run_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
